pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
- Downstream consumer of the free-running N-bit `counter`. It takes that counter's `count` output and produces a PWM waveform by comparing `count` against a duty register.
- Duty updates are double-buffered: a pending register is copied into the active register only at a period boundary, so every period is glitch-free.
- Includes a small enable/drain FSM so the output starts and stops on period boundaries only.

Parameters:
- N, 8, width of `count` and of the duty registers; must match the upstream `counter` N.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- count  input  N  free-running count from the upstream `counter`.
- enable  input  1  level; requests PWM run (1) or stop (0).
- duty  input  N  new duty value; sampled only when `load`=1.
- load  input  1  single-cycle strobe; captures `duty` into the pending register.
- pwm  output  1  registered PWM output.
- period_tick  output  1  one-cycle pulse on each detected wrap of `count`.
- duty_active  output  N  duty value currently in effect.
- pending  output  1  1 while a loaded duty value is waiting for the next wrap.
- running  output  1  1 in states RUN and DRAIN.

Behaviour:
- Reset (reset=0, asynchronous): pwm=0, period_tick=0, duty_active=0, pending=0, running=0, pending register=0, count_q=0, state=IDLE.
- count_q: registered copy of `count`.
- wrap = (count < count_q), unsigned compare. For a free-running counter this fires exactly on the max->0 transition.
- period_tick is registered: it equals the previous cycle's wrap (1-cycle latency).
- Wrap detection runs in every state, including IDLE.
- Shadow duty:
  - load=1 writes the pending register and sets pending=1.
  - On wrap with pending=1: duty_active <= pending register, pending <= 0.
  - load and wrap in the same cycle: the new `duty` goes straight to duty_active and pending stays 0 (bypass).
  - Back-to-back loads before a wrap: the last one wins.
- FSM states:
  - IDLE: enable=1 -> SYNC.
  - SYNC: wait for wrap. enable=0 -> IDLE. wrap with enable=1 -> RUN.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: wrap -> IDLE. enable=1 before the wrap -> RUN, with no gap in the output.
- pwm (registered): pwm <= (next state is RUN or DRAIN) && (count < next duty_active).
  - The first high cycle aligns with the cycle after the wrap that enters RUN.
  - The period is 2^N cycles; the high time is duty_active cycles.
  - duty_active=0 -> pwm stays 0 for the whole period.
  - Maximum high time is 2^N−1 (count=max is always low).
- running <= (next state is RUN or DRAIN).
- Mid-period reset: all outputs drop immediately (asynchronous). After release the block restarts from IDLE and needs a fresh enable plus a wrap before pwm goes high again.
- Upstream counter reset to 0 from a nonzero value is seen as a wrap; this is accepted behaviour.
- Non-monotonic `count` is outside the supported input range; the outputs then follow the rules above with no extra checking.

Optional Feature:
- Macro: PWM_PERIOD_CNT_EN.
- Defined:
  - Adds output port `periods` (16 bits): the number of completed periods spent in RUN or DRAIN.
  - Increments on wrap when the state is RUN or DRAIN; saturates at 16'hFFFF.
  - Cleared by reset and on the IDLE->SYNC transition.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (N=4 unless stated):
- Reset, then load duty=5 while in IDLE, enable=1, free-running count -> pending=1 until the first wrap, then duty_active=5, running=1. Every following 16-cycle period has pwm high for exactly 5 cycles (count 0..4, output 1 cycle late).
- Running at duty=5; load duty=12 at count=7 -> the current period keeps 5 high cycles; the next period has 12; pending clears on the wrap cycle.
- Load duty=3 in the same cycle as count goes 15->0 -> duty_active=3 in the cycle after, pending never asserts, and that same period has 3 high cycles.
- Drop enable at count=2 -> pwm completes the period, running falls after the wrap, and pwm=0 afterwards. Repeat, re-asserting enable at count=9 -> no missing high cycles.
- Duty 0 and duty 15 -> pwm never high; pwm high 15 of 16 cycles. period_tick pulses once per 16 cycles in all cases, including IDLE.
- Assert reset at count=3 while pwm=1 -> pwm, running and duty_active are 0 immediately, without waiting for a clock edge. With PWM_PERIOD_CNT_EN defined, `periods` after 4 full RUN periods equals 4 and reads 0 after reset.

Source files
------------

// File: rtl/pwm_gen.sv
// PWM generator driven by an external free-running counter, with double-buffered duty
// and an enable/drain FSM. Optional feature macro: PWM_PERIOD_CNT_EN adds `periods`.
module pwm_gen #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] count,
    input  logic         enable,
    input  logic [N-1:0] duty,
    input  logic         load,
    output logic         pwm,
    output logic         period_tick,
    output logic [N-1:0] duty_active,
    output logic         pending,
    output logic         running
`ifdef PWM_PERIOD_CNT_EN
    ,
    output logic [15:0]  periods
`endif
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] count_q;
    logic [N-1:0] pend_duty;
    logic [N-1:0] pend_duty_next;
    logic [N-1:0] duty_next;
    logic         pending_next;
    logic         active_next;
    logic         wrap;

    // A free-running counter only ever decreases on its max->0 step.
    assign wrap = (count < count_q);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = SYNC;
            SYNC: begin
                if (!enable)   state_next = IDLE;
                else if (wrap) state_next = RUN;
            end
            RUN:     if (!enable) state_next = DRAIN;
            DRAIN: begin
                if (wrap)        state_next = IDLE;
                else if (enable) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow duty: a load coinciding with a wrap bypasses the pending stage.
    always_comb begin
        duty_next      = duty_active;
        pending_next   = pending;
        pend_duty_next = pend_duty;
        if (load && wrap) begin
            duty_next      = duty;
            pend_duty_next = duty;
            pending_next   = 1'b0;
        end else if (load) begin
            pend_duty_next = duty;
            pending_next   = 1'b1;
        end else if (wrap && pending) begin
            duty_next    = pend_duty;
            pending_next = 1'b0;
        end
    end

    assign active_next = (state_next == RUN) || (state_next == DRAIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count_q     <= '0;
            period_tick <= 1'b0;
            duty_active <= '0;
            pend_duty   <= '0;
            pending     <= 1'b0;
            running     <= 1'b0;
            pwm         <= 1'b0;
        end else begin
            state       <= state_next;
            count_q     <= count;
            period_tick <= wrap;
            duty_active <= duty_next;
            pend_duty   <= pend_duty_next;
            pending     <= pending_next;
            running     <= active_next;
            pwm         <= active_next && (count < duty_next);
        end
    end

`ifdef PWM_PERIOD_CNT_EN
    // Counts periods completed while active; restarts on every new enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            periods <= '0;
        end else if (state == IDLE && state_next == SYNC) begin
            periods <= '0;
        end else if (wrap && (state == RUN || state == DRAIN) && periods != 16'hFFFF) begin
            periods <= periods + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen (N=4): the bench drives its own free-running count and
// checks every cycle through an expected-value queue, plus per-period high/tick totals.
module tb_pwm_gen;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] count;
    logic         enable;
    logic [N-1:0] duty;
    logic         load;
    logic         pwm;
    logic         period_tick;
    logic [N-1:0] duty_active;
    logic         pending;
    logic         running;
`ifdef PWM_PERIOD_CNT_EN
    logic [15:0]  periods;
`endif

    pwm_gen #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .enable      (enable),
        .duty        (duty),
        .load        (load),
        .pwm         (pwm),
        .period_tick (period_tick),
        .duty_active (duty_active),
        .pending     (pending),
        .running     (running)
`ifdef PWM_PERIOD_CNT_EN
        ,
        .periods     (periods)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Packed expectation: {pwm, running, period_tick, pending, duty_active}
    logic [7:0] exp_q[$];

    logic [N-1:0] cnt;
    logic [N-1:0] prev_cnt;
    logic         en_v;
    logic         ld_v;
    logic [N-1:0] d_v;
    logic         m_run;
    logic [N-1:0] m_duty;
    logic         m_pend;
    int           hi;
    int           tk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs for count=cnt, push the expected post-edge outputs
    // (m_* hold the state expected after this edge), then pop and compare.
    task automatic cyc(input string tag);
        logic       e_tick;
        logic [7:0] obs;
        logic [7:0] exp;
        enable = en_v;
        load   = ld_v;
        duty   = d_v;
        count  = cnt;
        e_tick = (prev_cnt == 4'd15) && (cnt == 4'd0);
        exp_q.push_back({m_run && (cnt < m_duty), m_run, e_tick, m_pend, m_duty});
        @(posedge clk);
        #1;
        obs = {pwm, running, period_tick, pending, duty_active};
        exp = exp_q.pop_front();
        chk($sformatf("%s_cnt%0d", tag, cnt), {8'h00, obs}, {8'h00, exp});
        hi       = hi + int'(pwm);
        tk       = tk + int'(period_tick);
        prev_cnt = cnt;
        cnt      = cnt + 4'd1;
    endtask

    task automatic end_period(input string tag, input int exp_hi);
        chk({tag, "_high"}, 16'(hi), 16'(exp_hi));
        chk({tag, "_ticks"}, 16'(tk), 16'd1);
        hi = 0;
        tk = 0;
    endtask

    initial begin
        reset  = 1'b0;
        count  = '0;
        enable = 1'b0;
        duty   = '0;
        load   = 1'b0;
        cnt = '0; prev_cnt = '0; en_v = 1'b0; ld_v = 1'b0; d_v = '0;
        m_run = 1'b0; m_duty = '0; m_pend = 1'b0; hi = 0; tk = 0;

        #2;
        chk("reset_state", {11'd0, pwm, running, period_tick, pending, 1'b0}, 16'd0);
        chk("reset_duty", {12'd0, duty_active}, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load 5 in IDLE, enable, wait for the first wrap.
        ld_v = 1'b1; d_v = 4'd5; m_pend = 1'b1;
        cyc("t1_load");
        ld_v = 1'b0; en_v = 1'b1;
        while (cnt != 4'd0) cyc("t1_sync");
        hi = 0; tk = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                if (cnt == 4'd0) begin m_run = 1'b1; m_duty = 4'd5; m_pend = 1'b0; end
                cyc("t1_run");
            end
            end_period("t1_period", 5);
        end

        // Load 12 mid-period: takes effect only at the next wrap.
        for (int i = 0; i < 16; i++) begin
            ld_v = (cnt == 4'd7);
            d_v  = 4'd12;
            if (cnt == 4'd7) m_pend = 1'b1;
            cyc("t2_cur");
        end
        ld_v = 1'b0;
        end_period("t2_cur", 5);
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd0) begin m_duty = 4'd12; m_pend = 1'b0; end
            cyc("t2_next");
        end
        end_period("t2_next", 12);

        // Load 3 exactly on the wrap cycle: bypass into duty_active.
        for (int i = 0; i < 16; i++) begin
            ld_v = (cnt == 4'd0);
            d_v  = 4'd3;
            if (cnt == 4'd0) m_duty = 4'd3;
            cyc("t3_bypass");
        end
        ld_v = 1'b0;
        end_period("t3_bypass", 3);

        // Drop enable at count 2: period completes, then idle.
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd2) en_v = 1'b0;
            cyc("t4_drain");
        end
        end_period("t4_drain", 3);
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd0) m_run = 1'b0;
            if (cnt == 4'd8) en_v = 1'b1;
            cyc("t4_idle");
        end
        end_period("t4_idle", 0);
        // Re-enter RUN, drop at 2 and re-assert at 9: no lost high cycles.
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd0) m_run = 1'b1;
            if (cnt == 4'd2) en_v = 1'b0;
            if (cnt == 4'd9) en_v = 1'b1;
            cyc("t4_reen");
        end
        end_period("t4_reen", 3);
        for (int i = 0; i < 16; i++) cyc("t4_after");
        end_period("t4_after", 3);

        // Duty 0 then duty 15.
        for (int i = 0; i < 16; i++) begin
            ld_v = (cnt == 4'd5);
            d_v  = 4'd0;
            if (cnt == 4'd5) m_pend = 1'b1;
            cyc("t5_ld0");
        end
        end_period("t5_ld0", 3);
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd0) begin m_duty = 4'd0; m_pend = 1'b0; end
            ld_v = (cnt == 4'd5);
            d_v  = 4'd15;
            if (cnt == 4'd5) m_pend = 1'b1;
            cyc("t5_duty0");
        end
        ld_v = 1'b0;
        end_period("t5_duty0", 0);
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd0) begin m_duty = 4'd15; m_pend = 1'b0; end
            cyc("t5_duty15");
        end
        end_period("t5_duty15", 15);

        // Asynchronous reset at count 3 while pwm is high.
        for (int i = 0; i < 3; i++) cyc("t6_pre");
        chk("t6_pwm_before_reset", {15'd0, pwm}, 16'd1);
        count = 4'd3;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_reset", {11'd0, pwm, running, period_tick, pending, 1'b0}, 16'd0);
        chk("t6_async_duty", {12'd0, duty_active}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cnt = 4'd3; prev_cnt = 4'd0;
        m_run = 1'b0; m_duty = 4'd0; m_pend = 1'b0;
        while (cnt != 4'd0) begin
            ld_v = (cnt == 4'd5);
            d_v  = 4'd7;
            if (cnt == 4'd5) m_pend = 1'b1;
            cyc("t6_resync");
        end
        ld_v = 1'b0;
        hi = 0; tk = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 16; i++) begin
                if (cnt == 4'd0) begin m_run = 1'b1; m_duty = 4'd7; m_pend = 1'b0; end
                cyc("t6_run");
            end
            end_period("t6_period", 7);
        end
        cyc("t6_wrap");
`ifdef PWM_PERIOD_CNT_EN
        chk("periods_after_4", periods, 16'd4);
`endif
        #2;
        reset = 1'b0;
        #1;
        chk("final_reset", {11'd0, pwm, running, period_tick, pending, 1'b0}, 16'd0);
        chk("final_reset_duty", {12'd0, duty_active}, 16'd0);
`ifdef PWM_PERIOD_CNT_EN
        chk("periods_reset", periods, 16'd0);
`endif
        chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
